// File: rtl/calc_ctrl_param.sv
// Keypad-driven sign-magnitude calculator controller with add/sub, shift-add multiply, clear, backspace and chaining.
// Latency: key_read 1 cycle after an event edge; add/sub result 2 cycles after equal; multiply WIDTH cycles after equal.
// Backpressure: none; events arriving while busy (or outside the entry states) are dropped.
//
// Ports:
//   clk, RST                       clock, synchronous active-high reset
//   keypad_input, read_input       digit value and its level strobe (rising edge = digit event)
//   operator_input                 operator level code (0 -> nonzero = operator event)
//   equal_input                    equal level strobe (rising edge = equal event)
//   key_read, complete             one-cycle pulses: event accepted / result written
//   overflow, busy                 sticky overflow flag / computation in progress
//   display_output                 sign-magnitude value shown on the display
module calc_ctrl_param #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [3:0]       keypad_input,
   input  logic             read_input,
   input  logic [2:0]       operator_input,
   input  logic             equal_input,
   output logic             key_read,
   output logic             complete,
   output logic             overflow,
   output logic             busy,
   output logic [WIDTH-1:0] display_output
);

   localparam int MW = WIDTH - 1;               // magnitude width
   localparam int PW = 2 * MW;                  // full product width
   localparam int CW = $clog2(MAX_DIGITS + 1);  // digit counter width
   localparam int IW = $clog2(MW);              // multiply iteration counter width

   localparam logic [2:0] OP_NEG  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_BKSP = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   typedef enum logic [2:0] {
      ENTRY_A,
      ENTRY_B,
      EXEC,
      MUL_RUN,
      RESULT
   } state_t;

   state_t state, state_nxt;

   // previous-value registers for edge detection
   logic          read_q;
   logic [2:0]    op_q;
   logic          eq_q;

   // operands, stored operator, result
   logic          a_sgn, b_sgn, res_sgn;
   logic [MW-1:0] a_mag, b_mag, res_mag;
   logic [CW-1:0] a_cnt, b_cnt;
   logic [2:0]    op_sel;
   logic          fresh;     // A holds a just-computed result; next digit starts a new number
   logic          ovf_q;
   logic          key_read_q;

   // multiplier state
   logic [PW-1:0] mul_acc, mul_mcand;
   logic [MW-1:0] mul_mplr;
   logic [IW-1:0] mul_cnt;

   // event decode
   logic rd_edge, op_edge, eq_edge, idle;
   logic ev_eq, ev_op, ev_dig;
   logic acc_eq, acc_op, acc_dig, accept;

   // active operand edit path
   logic          act_sgn, base_sgn, upd_sgn;
   logic [MW-1:0] act_mag, base_mag, upd_mag, times10, div10;
   logic [CW-1:0] act_cnt, base_cnt, upd_cnt;
   logic          wr_act;

   // add/sub path
   logic signed [WIDTH:0] sa, sb, ssum;
   logic [WIDTH:0]        sabs;
   logic                  as_ovf, as_sgn;
   logic [MW-1:0]         as_mag;

   // multiply step
   logic [PW-1:0] mul_nxt;
   logic          mul_ovf, mul_last, mul_sgn;
   logic [MW-1:0] mul_mag;

   assign rd_edge = read_input & ~read_q;
   assign op_edge = (operator_input != 3'd0) && (op_q == 3'd0);
   assign eq_edge = equal_input & ~eq_q;
   assign idle    = (state == ENTRY_A) || (state == ENTRY_B);

   always_comb begin
      ev_eq  = 1'b0;
      ev_op  = 1'b0;
      ev_dig = 1'b0;
      // only the highest-priority edge is considered; the rest are dropped
      if (idle) begin
         if (eq_edge)      ev_eq  = 1'b1;
         else if (op_edge) ev_op  = 1'b1;
         else if (rd_edge) ev_dig = 1'b1;
      end
   end

   always_comb begin
      act_sgn  = (state == ENTRY_B) ? b_sgn : a_sgn;
      act_mag  = (state == ENTRY_B) ? b_mag : a_mag;
      act_cnt  = (state == ENTRY_B) ? b_cnt : a_cnt;
      // a digit right after a result restarts A from zero
      base_sgn = (state == ENTRY_A && fresh) ? 1'b0 : act_sgn;
      base_mag = (state == ENTRY_A && fresh) ? '0   : act_mag;
      base_cnt = (state == ENTRY_A && fresh) ? '0   : act_cnt;
      times10  = (base_mag << 3) + (base_mag << 1);
      div10    = act_mag / MW'(10);

      acc_eq  = ev_eq && (state == ENTRY_B);
      acc_op  = ev_op && (operator_input != OP_RSVD);
      acc_dig = ev_dig && (keypad_input <= 4'd9) &&
                ((base_cnt < CW'(MAX_DIGITS)));
      accept  = acc_eq | acc_op | acc_dig;

      upd_sgn = act_sgn;
      upd_mag = act_mag;
      upd_cnt = act_cnt;
      wr_act  = 1'b0;
      if (acc_dig) begin
         upd_sgn = base_sgn;
         upd_mag = times10 + {{(MW-4){1'b0}}, keypad_input};
         upd_cnt = base_cnt + CW'(1);
         wr_act  = 1'b1;
      end else if (acc_op && operator_input == OP_NEG) begin
         upd_sgn = (act_mag != '0) ? ~act_sgn : 1'b0;
         wr_act  = 1'b1;
      end else if (acc_op && operator_input == OP_BKSP) begin
         if (act_cnt != '0) begin
            upd_mag = div10;
            upd_cnt = act_cnt - CW'(1);
            upd_sgn = (div10 != '0) ? act_sgn : 1'b0;  // never leave a negative zero
         end
         wr_act = 1'b1;
      end
   end

   // sign-magnitude add/sub via one extra bit of two's complement headroom
   always_comb begin
      sa = $signed({2'b00, a_mag});
      if (a_sgn) sa = -sa;
      sb = $signed({2'b00, b_mag});
      if (b_sgn ^ (op_sel == OP_SUB)) sb = -sb;
      ssum   = sa + sb;
      sabs   = ssum[WIDTH] ? $unsigned(-ssum) : $unsigned(ssum);
      as_ovf = |sabs[WIDTH:MW];
      as_mag = as_ovf ? '0 : sabs[MW-1:0];
      as_sgn = ~as_ovf & ssum[WIDTH] & (sabs[MW-1:0] != '0);
   end

   always_comb begin
      mul_nxt  = mul_acc + (mul_mplr[0] ? mul_mcand : '0);
      mul_ovf  = |mul_nxt[PW-1:MW];
      mul_mag  = mul_ovf ? '0 : mul_nxt[MW-1:0];
      mul_sgn  = ~mul_ovf & (a_sgn ^ b_sgn) & (mul_nxt[MW-1:0] != '0);
      mul_last = (mul_cnt == IW'(MW - 1));
   end

   always_ff @(posedge clk) begin
      if (RST) state <= ENTRY_A;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ENTRY_A, ENTRY_B: begin
            if (acc_op && operator_input == OP_CLR)
               state_nxt = ENTRY_A;
            else if (acc_op && state == ENTRY_A &&
                     (operator_input == OP_ADD || operator_input == OP_SUB ||
                      operator_input == OP_MUL))
               state_nxt = ENTRY_B;
            else if (acc_eq)
               state_nxt = (op_sel == OP_MUL) ? MUL_RUN : EXEC;
         end
         EXEC:    state_nxt = RESULT;
         MUL_RUN: if (mul_last) state_nxt = RESULT;
         RESULT:  state_nxt = ENTRY_A;
         default: state_nxt = ENTRY_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         read_q     <= 1'b0;
         op_q       <= '0;
         eq_q       <= 1'b0;
         a_sgn      <= 1'b0;
         a_mag      <= '0;
         a_cnt      <= '0;
         b_sgn      <= 1'b0;
         b_mag      <= '0;
         b_cnt      <= '0;
         res_sgn    <= 1'b0;
         res_mag    <= '0;
         op_sel     <= '0;
         fresh      <= 1'b0;
         ovf_q      <= 1'b0;
         key_read_q <= 1'b0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplr   <= '0;
         mul_cnt    <= '0;
      end else begin
         read_q     <= read_input;
         op_q       <= operator_input;
         eq_q       <= equal_input;
         key_read_q <= accept;

         if (accept) begin
            ovf_q <= 1'b0;
            fresh <= 1'b0;
         end

         if (wr_act) begin
            if (state == ENTRY_B) begin
               b_sgn <= upd_sgn;
               b_mag <= upd_mag;
               b_cnt <= upd_cnt;
            end else begin
               a_sgn <= upd_sgn;
               a_mag <= upd_mag;
               a_cnt <= upd_cnt;
            end
         end

         if (acc_op) begin
            case (operator_input)
               OP_ADD, OP_SUB, OP_MUL: begin
                  op_sel <= operator_input;
                  if (state == ENTRY_A) begin
                     b_sgn <= 1'b0;
                     b_mag <= '0;
                     b_cnt <= '0;
                  end
               end
               OP_CLR: begin
                  a_sgn  <= 1'b0;
                  a_mag  <= '0;
                  a_cnt  <= '0;
                  b_sgn  <= 1'b0;
                  b_mag  <= '0;
                  b_cnt  <= '0;
                  op_sel <= '0;
               end
               default: ;
            endcase
         end

         if (acc_eq && op_sel == OP_MUL) begin
            mul_acc   <= '0;
            mul_mcand <= {{MW{1'b0}}, a_mag};
            mul_mplr  <= b_mag;
            mul_cnt   <= '0;
         end

         if (state == EXEC) begin
            res_sgn <= as_sgn;
            res_mag <= as_mag;
            ovf_q   <= as_ovf;
         end

         // one multiplier bit per cycle; the last step writes the result directly
         if (state == MUL_RUN) begin
            mul_acc   <= mul_nxt;
            mul_mcand <= mul_mcand << 1;
            mul_mplr  <= mul_mplr >> 1;
            mul_cnt   <= mul_cnt + IW'(1);
            if (mul_last) begin
               res_sgn <= mul_sgn;
               res_mag <= mul_mag;
               ovf_q   <= mul_ovf;
            end
         end

         // result becomes A; A is full so only a fresh digit can replace it
         if (state == RESULT) begin
            a_sgn <= res_sgn;
            a_mag <= res_mag;
            a_cnt <= CW'(MAX_DIGITS);
            b_sgn <= 1'b0;
            b_mag <= '0;
            b_cnt <= '0;
            fresh <= 1'b1;
         end
      end
   end

   always_comb begin
      case (state)
         ENTRY_A:                 display_output = {a_sgn, a_mag};
         ENTRY_B, EXEC, MUL_RUN:  display_output = {b_sgn, b_mag};
         RESULT:                  display_output = {res_sgn, res_mag};
         default:                 display_output = '0;
      endcase
   end

   assign key_read = key_read_q;
   assign complete = (state == RESULT);
   assign busy     = (state == EXEC) || (state == MUL_RUN);
   assign overflow = ovf_q;

endmodule

// File: doc/calc_ctrl_param.md
# calc_ctrl_param

Parametrised successor to the calculator general controller. It is a keypad-driven sign-magnitude calculator controller with a configurable operand width and digit limit. It adds clear, backspace, result chaining and overflow detection, and contains its own single-cycle add/subtract path and iterative shift-add multiplier. It sits between the input controller (keypad/operator/equal decode) and the display driver.

## Interface
- `WIDTH`, default 16: operand/result width. Bit `WIDTH-1` is the sign; bits `WIDTH-2:0` are the magnitude. Must be ≥ 8.
- `MAX_DIGITS`, default 4: maximum decimal digits per operand. Must satisfy 10^MAX_DIGITS − 1 ≤ 2^(WIDTH−1) − 1.
- `clk`  in  1  system clock. One clock domain only.
- `RST`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `keypad_input`  in  4  digit value, valid while `read_input` is high.
- `read_input`  in  1  level; a rising edge is one digit event.
- `operator_input`  in  3  level code:
  - 0 none, 1 negate, 2 add, 3 sub, 4 mul, 5 clear, 6 backspace, 7 reserved (ignored).
  - A change from 0 to nonzero is one operator event.
- `equal_input`  in  1  level; a rising edge is one equal event.
- `key_read`  out  1  one-cycle acknowledge of each accepted event.
- `complete`  out  1  one-cycle pulse when a result is written.
- `overflow`  out  1  sticky; set by an overflowing result, cleared by the next accepted event.
- `busy`  out  1  high while computing.
- `display_output`  out  WIDTH  sign-magnitude value currently displayed.

## Operation
- **Event detection.** Registered previous values of `read_input`, `operator_input` and `equal_input` are used to detect events.
  - Priority when events coincide in one cycle: equal > operator > digit. Only one event is accepted; the others are dropped.
  - While `busy`, all events are dropped, but the previous-value registers keep updating.
- **States:** `ENTRY_A` → (add/sub/mul) → `ENTRY_B` → (equal) → `EXEC` or `MUL_RUN` → `RESULT` → `ENTRY_A`.
- **Digit event**, active operand only (A in `ENTRY_A`, B in `ENTRY_B`):
  - magnitude ← magnitude·10 + digit, with ·10 computed as (m<<3)+(m<<1); digit count increments.
  - Ignored (no `key_read`) if `keypad_input` > 9 or the digit count already equals `MAX_DIGITS`.
- **Negate:** toggles the sign bit of the active operand. A zero magnitude keeps the sign at 0.
- **Backspace:**
  - magnitude ← magnitude/10 (constant divide); digit count decrements.
  - With count 0: no effect, but `key_read` still pulses.
- **Clear:** from any non-busy state, A, B, digit counts, stored operator and `overflow` are all zeroed; state → `ENTRY_A`.
- **Add/sub/mul in `ENTRY_A`:** stores the operator, clears B, goes to `ENTRY_B`.
- **Add/sub/mul in `ENTRY_B`:** replaces the stored operator only; B is retained.
- **Equal:**
  - In `ENTRY_A`: ignored, no `key_read`.
  - In `ENTRY_B`: add/sub → `EXEC`; mul → `MUL_RUN`.
- **Add/sub:** signed addition of the two sign-magnitude operands (sub negates B first).
  - Result magnitude > 2^(WIDTH−1)−1 → result 0, `overflow` = 1.
  - A zero result always has sign 0.
- **Mul:** shift-add over the WIDTH−1 magnitude bits, one bit per cycle. Sign = sign(A) xor sign(B).
  - Overflow if any product bit above WIDTH−2 is set → result 0, `overflow` = 1.
- **`RESULT` state:**
  - A ← result, B ← 0, A digit count ← `MAX_DIGITS` (further digits are ignored); go to `ENTRY_A`.
  - Chaining: an operator event next uses the result as A.
  - A digit event in `ENTRY_A` immediately after a result first clears A, then enters the digit.
- **`display_output`:** A in `ENTRY_A`; B in `ENTRY_B`; the result from `RESULT` onward.

## Timing
- **Reset** (`RST` high at a `clk` edge): state `ENTRY_A`, all registers 0. All outputs 0: `key_read`, `complete`, `overflow`, `busy` and `display_output`.
  - Reset mid-`MUL_RUN` aborts the multiply with no `complete`.
- **Event edge sampled at cycle N:**
  - `key_read` = 1 in cycle N+1 only.
  - Operand and `display_output` updated in cycle N+1.
- **Add/sub** (equal accepted at N):
  - `busy` = 1 in N+1.
  - Result on `display_output` and `complete` = 1 in N+2.
  - `busy` = 0 in N+2.
- **Mul** (equal accepted at N):
  - `busy` = 1 from N+1 through N+WIDTH−1 (WIDTH−1 iteration cycles).
  - Result and `complete` in N+WIDTH.
- **Pulse widths:** `complete` and `key_read` are never high for more than one consecutive cycle per event.
- **Held inputs:** a level held high produces exactly one event.

## Test plan
- Enter 1, 2, +, 3, 4, = (WIDTH=16) → `key_read` once per event; `display_output` 0x000C then 0x0022; `complete` at N+2 after equal; display 0x002E.
- Enter 7, negate, *, 6, = → `busy` for 15 cycles; `complete` at N+16; display 0x802A; `overflow` 0.
- Enter 1, 2, 3, 4, 5 → fifth digit gets no `key_read`; display stays 0x04D2. Then backspace → 0x007B. Then clear → 0x0000.
- 9999 * 9999 = → `overflow` = 1, display 0x0000. Next digit event clears `overflow`.
- Result 46 (0x002E), then +, 4, = → chained result 0x0032. A digit 5 right after a result → display 0x0005.
- Simultaneous `read_input` and `equal_input` edges in `ENTRY_B` → only equal is accepted. Assert `RST` during `MUL_RUN` → next cycle all outputs 0, no `complete`.
